core_dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single core data-memory port between the pipeline LSU (port C) and a secondary master such as the debug module or a trace or DMA engine (port X). It sits between the execute/writeback LSU logic and the external `dmem_*` bus. Requests are forwarded with zero added latency, and a granted selection stays locked until the memory grants. The read response and error that arrive one cycle after each grant are steered back to the requester that owns that transaction.

---
 rtl/core_dmem_arbiter_pkg.sv | 23 ++
 rtl/core_dmem_arb_pick.sv | 58 +++++
 rtl/core_dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_core_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_dmem_arbiter_pkg.sv
// Shared definitions for the core data-memory arbiter: common widths, lock states, requester ids.
// The round-robin policy is selected with the CORE_DMEM_ARB_RR_EN macro (see core_dmem_arb_pick).
package core_dmem_arbiter_pkg;

  localparam int CORE_AW = 64;
  localparam int CORE_DW = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_C = 2'd1,
    LOCK_X = 2'd2
  } arb_state_t;

  localparam logic ARB_ID_C = 1'b0;
  localparam logic ARB_ID_X = 1'b1;

  // vld=0 means nothing is selected this cycle; id is then don't-care
  typedef struct packed {
    logic vld;
    logic id;
  } arb_sel_t;

endpackage

// File: rtl/core_dmem_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
// Default is fixed C priority with starvation escape; CORE_DMEM_ARB_RR_EN selects round-robin.
module core_dmem_arb_pick
  import core_dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             c_req,
  input  logic             x_req,
  input  arb_state_t       state,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic             last_winner,
  output arb_sel_t         sel
);

  logic tie_id;

`ifdef CORE_DMEM_ARB_RR_EN
  logic unused_starve;
  assign unused_starve = ^starve_cnt;
  assign tie_id        = (last_winner == ARB_ID_C) ? ARB_ID_X : ARB_ID_C;
`else
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  logic unused_last;
  assign unused_last = last_winner;
  assign tie_id      = (starve_cnt == STARVE_MAX) ? ARB_ID_X : ARB_ID_C;
`endif

  // A locked owner keeps the port; dropping its request while locked selects nobody.
  always_comb begin
    sel.vld = 1'b0;
    sel.id  = ARB_ID_C;
    unique case (state)
      LOCK_C: begin
        sel.vld = c_req;
        sel.id  = ARB_ID_C;
      end
      LOCK_X: begin
        sel.vld = x_req;
        sel.id  = ARB_ID_X;
      end
      default: begin
        if (c_req && x_req) begin
          sel.vld = 1'b1;
          sel.id  = tie_id;
        end else if (x_req) begin
          sel.vld = 1'b1;
          sel.id  = ARB_ID_X;
        end else if (c_req) begin
          sel.vld = 1'b1;
          sel.id  = ARB_ID_C;
        end
      end
    endcase
  end

endmodule

// File: rtl/core_dmem_arbiter.sv
// Shares the core data-memory port between the LSU (C) and a secondary master (X).
// Policy is fixed priority by default; define CORE_DMEM_ARB_RR_EN for round-robin.
module core_dmem_arbiter
  import core_dmem_arbiter_pkg::*;
#(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  input  logic            c_req,
  input  logic [AW-1:0]   c_addr,
  input  logic            c_wen,
  input  logic [DW/8-1:0] c_strb,
  input  logic [DW-1:0]   c_wdata,
  output logic            c_gnt,
  output logic            c_rsp,
  output logic            c_err,
  output logic [DW-1:0]   c_rdata,

  input  logic            x_req,
  input  logic [AW-1:0]   x_addr,
  input  logic            x_wen,
  input  logic [DW/8-1:0] x_strb,
  input  logic [DW-1:0]   x_wdata,
  output logic            x_gnt,
  output logic            x_rsp,
  output logic            x_err,
  output logic [DW-1:0]   x_rdata,

  output logic            dmem_req,
  output logic [AW-1:0]   dmem_addr,
  output logic            dmem_wen,
  output logic [DW/8-1:0] dmem_strb,
  output logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_err,
  input  logic [DW-1:0]   dmem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_sel_t         pick_sel;
  logic             sel_vld;
  logic             sel_id;
  logic             dmem_fire;
  logic [CNT_W-1:0] starve_cnt;
  logic             last_winner;
  logic             rsp_pend;
  logic             rsp_owner;
  logic             c_hit;
  logic             x_hit;

  core_dmem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .c_req       (c_req),
    .x_req       (x_req),
    .state       (state),
    .starve_cnt  (starve_cnt),
    .last_winner (last_winner),
    .sel         (pick_sel)
  );

  // Selection is masked during reset so every output reads zero while g_resetn is low.
  assign sel_vld   = pick_sel.vld && g_resetn;
  assign sel_id    = pick_sel.id;
  assign dmem_fire = sel_vld && dmem_gnt;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sel_vld && !dmem_gnt) begin
          state_nxt = (sel_id == ARB_ID_X) ? LOCK_X : LOCK_C;
        end
      end
      LOCK_C: begin
        if (!c_req || dmem_gnt) state_nxt = IDLE;
      end
      LOCK_X: begin
        if (!x_req || dmem_gnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_req   = sel_vld;
    dmem_addr  = '0;
    dmem_wen   = 1'b0;
    dmem_strb  = '0;
    dmem_wdata = '0;
    if (sel_vld) begin
      if (sel_id == ARB_ID_X) begin
        dmem_addr  = x_addr;
        dmem_wen   = x_wen;
        dmem_strb  = x_strb;
        dmem_wdata = x_wdata;
      end else begin
        dmem_addr  = c_addr;
        dmem_wen   = c_wen;
        dmem_strb  = c_strb;
        dmem_wdata = c_wdata;
      end
    end
    c_gnt   = dmem_fire && (sel_id == ARB_ID_C);
    x_gnt   = dmem_fire && (sel_id == ARB_ID_X);
    c_hit   = g_resetn && rsp_pend && (rsp_owner == ARB_ID_C);
    x_hit   = g_resetn && rsp_pend && (rsp_owner == ARB_ID_X);
    c_rsp   = c_hit;
    x_rsp   = x_hit;
    c_err   = c_hit && dmem_err;
    x_err   = x_hit && dmem_err;
    c_rdata = c_hit ? dmem_rdata : '0;
    x_rdata = x_hit ? dmem_rdata : '0;
  end

  // The response always lands one cycle after the grant, so one pending bit suffices.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rsp_pend  <= 1'b0;
      rsp_owner <= ARB_ID_C;
    end else begin
      rsp_pend <= dmem_fire;
      if (dmem_fire) rsp_owner <= sel_id;
    end
  end

`ifdef CORE_DMEM_ARB_RR_EN
  assign starve_cnt = '0;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      last_winner <= ARB_ID_C;
    end else if (dmem_fire) begin
      last_winner <= sel_id;
    end
  end
`else
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  assign last_winner = ARB_ID_C;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      starve_cnt <= '0;
    end else if (!x_req || x_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Self-checking bench for core_dmem_arbiter: directed scenarios plus randomized traffic
// against a behavioural model; honours CORE_DMEM_ARB_RR_EN the same way as the design.
module tb_core_dmem_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int SW    = DW / 8;
  localparam int LIMIT = 8;

  logic          g_clk = 1'b0;
  logic          g_resetn;
  logic          c_req, x_req, c_wen, x_wen;
  logic [AW-1:0] c_addr, x_addr;
  logic [SW-1:0] c_strb, x_strb;
  logic [DW-1:0] c_wdata, x_wdata;
  logic          c_gnt, c_rsp, c_err, x_gnt, x_rsp, x_err;
  logic [DW-1:0] c_rdata, x_rdata;
  logic          dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [AW-1:0] dmem_addr;
  logic [SW-1:0] dmem_strb;
  logic [DW-1:0] dmem_wdata, dmem_rdata;

  core_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .c_req(c_req), .c_addr(c_addr), .c_wen(c_wen), .c_strb(c_strb), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rsp(c_rsp), .c_err(c_err), .c_rdata(c_rdata),
    .x_req(x_req), .x_addr(x_addr), .x_wen(x_wen), .x_strb(x_strb), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rsp(x_rsp), .x_err(x_err), .x_rdata(x_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
  );

  always #5 g_clk = ~g_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: owner of a stalled request (-1 none, 0 C, 1 X), lost-cycle count,
  // last grant winner, and the owner of the response due this cycle.
  int m_lock, m_starve, m_last, m_rsp, m_sel;
  bit m_gnt_c, m_gnt_x;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int modelWinner();
    if (!g_resetn) return -1;
    if (m_lock == 0) return c_req ? 0 : -1;
    if (m_lock == 1) return x_req ? 1 : -1;
    if (c_req && x_req) begin
`ifdef CORE_DMEM_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return (m_starve >= LIMIT) ? 1 : 0;
`endif
    end
    if (c_req) return 0;
    if (x_req) return 1;
    return -1;
  endfunction

  task automatic applyStimulus(input bit cr, input logic [63:0] ca, input bit xr,
                               input logic [63:0] xa, input bit gnt, input bit err,
                               input logic [63:0] rd);
    logic [63:0] e_addr, e_wdata;
    logic [8:0]  e_ws;
    bit          e_c, e_x;
    c_req = cr; c_addr = ca; c_wen = ca[3]; c_strb = ca[7:0] ^ 8'h5A; c_wdata = ~ca;
    x_req = xr; x_addr = xa; x_wen = xa[3]; x_strb = xa[7:0] ^ 8'h5A; x_wdata = ~xa;
    dmem_gnt = gnt; dmem_err = err; dmem_rdata = rd;
    #1;
    m_sel   = modelWinner();
    e_addr  = (m_sel == 0) ? ca : (m_sel == 1) ? xa : 64'h0;
    e_wdata = (m_sel < 0) ? 64'h0 : ~e_addr;
    e_ws    = (m_sel < 0) ? 9'h0 : {e_addr[3], e_addr[7:0] ^ 8'h5A};
    m_gnt_c = gnt && (m_sel == 0);
    m_gnt_x = gnt && (m_sel == 1);
    e_c     = g_resetn && (m_rsp == 0);
    e_x     = g_resetn && (m_rsp == 1);
    checkOutput("dmem_req", dmem_req, (m_sel >= 0));
    checkOutput("dmem_addr", dmem_addr, e_addr);
    checkOutput("dmem_wen_strb", {dmem_wen, dmem_strb}, e_ws);
    checkOutput("dmem_wdata", dmem_wdata, e_wdata);
    checkOutput("c_gnt", c_gnt, m_gnt_c);
    checkOutput("x_gnt", x_gnt, m_gnt_x);
    checkOutput("c_rsp", c_rsp, e_c);
    checkOutput("x_rsp", x_rsp, e_x);
    checkOutput("c_err", c_err, e_c && err);
    checkOutput("x_err", x_err, e_x && err);
    checkOutput("c_rdata", c_rdata, e_c ? rd : 64'h0);
    checkOutput("x_rdata", x_rdata, e_x ? rd : 64'h0);
  endtask

  task automatic finishCycle();
    @(posedge g_clk);
    if (!g_resetn) begin
      m_lock = -1; m_starve = 0; m_last = 0; m_rsp = -1;
    end else begin
      if (m_lock == 0 && (!c_req || dmem_gnt)) m_lock = -1;
      else if (m_lock == 1 && (!x_req || dmem_gnt)) m_lock = -1;
      else if (m_lock == -1 && m_sel >= 0 && !dmem_gnt) m_lock = m_sel;
      if (!x_req || m_gnt_x) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (m_sel >= 0 && dmem_gnt) begin
        m_rsp  = m_sel;
        m_last = m_sel;
      end else begin
        m_rsp = -1;
      end
    end
    #1;
  endtask

  logic [9:0]  seq;
  logic [9:0]  seq_exp;
  bit          c_act, x_act;
  logic [63:0] c_a, x_a;

  initial begin
    g_resetn = 1'b0;
    m_lock = -1; m_starve = 0; m_last = 0; m_rsp = -1; m_sel = -1;
    c_act = 0; x_act = 0; c_a = '0; x_a = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge g_clk);
    #1;

    // Reset with live requests: everything must read zero
    applyStimulus(1, 64'h1000, 1, 64'h2000, 1, 1, 64'h1234);
    checkOutput("reset_req", dmem_req, 1'b0);
    finishCycle();
    g_resetn = 1'b1;

    // C only
    applyStimulus(1, 64'h1000, 0, 0, 1, 0, 0);
    checkOutput("c_only_addr", dmem_addr, 64'h1000);
    checkOutput("c_only_gnt", c_gnt, 1'b1);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 64'hDEAD);
    checkOutput("c_only_rdata", c_rdata, 64'hDEAD);
    checkOutput("c_only_xrsp", x_rsp, 1'b0);
    finishCycle();

    // Stall lock on X, then C arrives
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 64'h2000, 0, 0, 64'h55);
      finishCycle();
    end
    applyStimulus(1, 64'h3000, 1, 64'h2000, 0, 0, 0);
    checkOutput("lock_addr", dmem_addr, 64'h2000);
    finishCycle();
    applyStimulus(1, 64'h3000, 1, 64'h2000, 1, 0, 0);
    checkOutput("lock_xgnt", x_gnt, 1'b1);
    finishCycle();
    applyStimulus(1, 64'h3000, 0, 0, 1, 0, 0);
    checkOutput("after_lock_cgnt", c_gnt, 1'b1);
    checkOutput("after_lock_addr", dmem_addr, 64'h3000);
    finishCycle();

    // Both requesting continuously with the memory always ready
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 64'h3100 + 64'(i), 1, 64'h4100, 1, 0, 0);
      seq[i] = x_gnt;
      finishCycle();
    end
`ifdef CORE_DMEM_ARB_RR_EN
    seq_exp = 10'b01_0101_0101;
`else
    seq_exp = 10'b01_0000_0000;
`endif
    checkOutput("policy_seq", seq, seq_exp);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    finishCycle();

    // Back-to-back X then C, error on X's response
    applyStimulus(0, 0, 1, 64'h4000, 1, 0, 0);
    finishCycle();
    applyStimulus(1, 64'h5000, 0, 0, 1, 1, 64'hBEEF);
    checkOutput("b2b_xerr", x_err, 1'b1);
    checkOutput("b2b_cerr", c_err, 1'b0);
    checkOutput("b2b_cgnt", c_gnt, 1'b1);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 64'hCAFE);
    checkOutput("b2b_crsp", c_rsp, 1'b1);
    checkOutput("b2b_crdata", c_rdata, 64'hCAFE);
    finishCycle();

    // Reset while X is locked and its grant is in flight
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1, 64'h6000, 0, 0, 0);
      finishCycle();
    end
    applyStimulus(0, 0, 1, 64'h6000, 1, 0, 0);
    finishCycle();
    g_resetn = 1'b0;
    applyStimulus(0, 0, 1, 64'h6000, 1, 1, 64'h99);
    checkOutput("rst_x_rsp", x_rsp, 1'b0);
    checkOutput("rst_dmem_req", dmem_req, 1'b0);
    finishCycle();
    g_resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h77);
    checkOutput("post_rst_xrsp", x_rsp, 1'b0);
    checkOutput("post_rst_crsp", c_rsp, 1'b0);
    finishCycle();

    // Randomized traffic; losers hold, occasional request drops while stalled
    for (int i = 0; i < 400; i++) begin
      if (!c_act && $urandom_range(1, 0) == 1) begin
        c_act = 1; c_a = {$urandom, $urandom};
      end else if (c_act && $urandom_range(31, 0) == 0) begin
        c_act = 0;
      end
      if (!x_act && $urandom_range(1, 0) == 1) begin
        x_act = 1; x_a = {$urandom, $urandom};
      end else if (x_act && $urandom_range(31, 0) == 0) begin
        x_act = 0;
      end
      applyStimulus(c_act, c_a, x_act, x_a, ($urandom_range(3, 0) != 0),
                    1'($urandom_range(1, 0)), {$urandom, $urandom});
      if (m_gnt_c) c_act = 0;
      if (m_gnt_x) x_act = 0;
      finishCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
